// File: rtl/mp_latency_ram.sv
// mp_latency_ram: N-port RAM with per-port write-commit and read-return pipelines.
// Colliding writes resolve to the lowest port; out-of-range requests are masked.
module mp_latency_ram #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int WR_LATENCY = 1,
    parameter int RD_LATENCY = 1,
    parameter int RW_MODE    = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            i_en,
    input  logic [NUM_PORTS-1:0]            i_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_din,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] o_dout,
    output logic [NUM_PORTS-1:0]            o_rvalid,
    output logic [NUM_PORTS-1:0]            o_wr_drop
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NA = NUM_PORTS * ADDR_WIDTH;
    localparam int ND = NUM_PORTS * DATA_WIDTH;

    if (64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("mp_latency_ram: DEPTH exceeds 2**ADDR_WIDTH");
    end
    if (WR_LATENCY < 1) begin : g_bad_wr
        $error("mp_latency_ram: WR_LATENCY must be >= 1");
    end
    if (RD_LATENCY < 1) begin : g_bad_rd
        $error("mp_latency_ram: RD_LATENCY must be >= 1");
    end

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Commit-stage view of each port's write: valid, address, data.
    logic [NUM_PORTS-1:0] cv;
    logic [NA-1:0]        ca;
    logic [ND-1:0]        cd;

    if (WR_LATENCY == 1) begin : g_wr_direct
        assign cv = i_en & i_we;
        assign ca = i_addr;
        assign cd = i_din;
    end else begin : g_wr_pipe
        localparam int S = WR_LATENCY - 1;
        logic [NUM_PORTS-1:0] pv [S];
        logic [NA-1:0]        pa [S];
        logic [ND-1:0]        pd [S];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < S; s++) begin
                    pv[s] <= '0;
                    pa[s] <= '0;
                    pd[s] <= '0;
                end
            end else begin
                pv[0] <= i_en & i_we;
                pa[0] <= i_addr;
                pd[0] <= i_din;
                for (int s = 1; s < S; s++) begin
                    pv[s] <= pv[s-1];
                    pa[s] <= pa[s-1];
                    pd[s] <= pd[s-1];
                end
            end
        end

        assign cv = pv[S-1];
        assign ca = pa[S-1];
        assign cd = pd[S-1];
    end

    logic [NUM_PORTS-1:0] wok;
    logic [NUM_PORTS-1:0] lose;

    always_comb begin
        wok  = '0;
        lose = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wok[p] = cv[p] && in_range(ca[p*ADDR_WIDTH +: ADDR_WIDTH]);
        end
        // A commit loses to any lower port committing to the same word.
        for (int p = 1; p < NUM_PORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                if (wok[p] && wok[q] &&
                    ca[p*ADDR_WIDTH +: ADDR_WIDTH] == ca[q*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    lose[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wok[p] && !lose[p]) begin
                mem[ca[p*ADDR_WIDTH +: IW]] <= cd[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    logic [ND-1:0] rd;

    always_comb begin
        logic [ADDR_WIDTH-1:0] a;
        a  = '0;
        rd = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            a = i_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (in_range(a)) begin
                rd[p*DATA_WIDTH +: DATA_WIDTH] = mem[a[IW-1:0]];
                if (RW_MODE != 0) begin
                    for (int q = 0; q < NUM_PORTS; q++) begin
                        if (wok[q] && !lose[q] &&
                            ca[q*ADDR_WIDTH +: ADDR_WIDTH] == a) begin
                            rd[p*DATA_WIDTH +: DATA_WIDTH] = cd[q*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
        end
    end

    logic [NUM_PORTS-1:0] rv;
    logic [NUM_PORTS-1:0] sv;
    logic [ND-1:0]        sd;

    assign rv = i_en & ~i_we;

    if (RD_LATENCY == 1) begin : g_rd_direct
        assign sv = rv;
        assign sd = rd;
    end else begin : g_rd_pipe
        localparam int S = RD_LATENCY - 1;
        logic [NUM_PORTS-1:0] qv [S];
        logic [ND-1:0]        qd [S];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < S; s++) begin
                    qv[s] <= '0;
                    qd[s] <= '0;
                end
            end else begin
                qv[0] <= rv;
                qd[0] <= rd;
                for (int s = 1; s < S; s++) begin
                    qv[s] <= qv[s-1];
                    qd[s] <= qd[s-1];
                end
            end
        end

        assign sv = qv[S-1];
        assign sd = qd[S-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dout    <= '0;
            o_rvalid  <= '0;
            o_wr_drop <= '0;
        end else begin
            o_rvalid  <= sv;
            o_wr_drop <= wok & lose;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sv[p]) begin
                    o_dout[p*DATA_WIDTH +: DATA_WIDTH] <= sd[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_latency_ram.sv
// Bench for mp_latency_ram: three parameterisations run side by side, each with
// an edge-indexed reference model feeding per-port scoreboard queues.
module tb_mp_latency_ram;
    localparam int NP          = 2;
    localparam int DW          = 32;
    localparam int AW          = 8;
    localparam int NINST       = 3;
    localparam int RAND_CYCLES = 10000;

    typedef struct {
        int            e;
        int            p;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int            e;
        logic [DW-1:0] d;
    } rd_t;

    typedef struct {
        int            e;
        logic [NP-1:0] mask;
    } dr_t;

    logic clk    = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NINST; g++) begin : g_i
        localparam int WR    = (g == 0) ? 3 : (g == 1) ? 1 : 4;
        localparam int RD    = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        localparam int RW    = (g == 0) ? 0 : 1;
        localparam int DEPTH = (g == 2) ? 200 : 256;

        logic             rst_n = 1'b1;
        logic [NP-1:0]    en    = '0;
        logic [NP-1:0]    we    = '0;
        logic [NP*AW-1:0] addr  = '0;
        logic [NP*DW-1:0] din   = '0;
        logic [NP*DW-1:0] dout;
        logic [NP-1:0]    rvalid;
        logic [NP-1:0]    drop;
        bit               done  = 1'b0;

        logic [DW-1:0] ref_mem [256];
        logic [DW-1:0] last [NP];
        wr_t           pend [$];
        rd_t           rq [NP][$];
        dr_t           dq [$];

        mp_latency_ram #(
            .NUM_PORTS (NP),
            .DATA_WIDTH(DW),
            .ADDR_WIDTH(AW),
            .DEPTH     (DEPTH),
            .WR_LATENCY(WR),
            .RD_LATENCY(RD),
            .RW_MODE   (RW)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (en),
            .i_we     (we),
            .i_addr   (addr),
            .i_din    (din),
            .o_dout   (dout),
            .o_rvalid (rvalid),
            .o_wr_drop(drop)
        );

        function automatic bit inr(input logic [AW-1:0] a);
            return int'(a) < DEPTH;
        endfunction

        // What the RAM must do at edge e given the requests presented for it.
        task automatic model_edge(input int e);
            wr_t           c [$];
            wr_t           w;
            rd_t           r;
            dr_t           dr;
            logic [NP-1:0] dm;
            logic [AW-1:0] a;
            logic [DW-1:0] v;
            dm = '0;
            for (int p = 0; p < NP; p++) begin
                if (en[p] && we[p]) begin
                    w.e = e;
                    w.p = p;
                    w.a = addr[p*AW +: AW];
                    w.d = din[p*DW +: DW];
                    pend.push_back(w);
                end
            end
            while (pend.size() > 0 && pend[0].e + WR - 1 == e) begin
                if (inr(pend[0].a)) c.push_back(pend[0]);
                void'(pend.pop_front());
            end
            for (int i = 0; i < c.size(); i++) begin
                for (int j = 0; j < c.size(); j++) begin
                    if (c[j].a == c[i].a && c[j].p < c[i].p) dm[c[i].p] = 1'b1;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (en[p] && !we[p]) begin
                    a = addr[p*AW +: AW];
                    v = '0;
                    if (inr(a)) begin
                        v = ref_mem[a];
                        if (RW == 1) begin
                            for (int i = 0; i < c.size(); i++) begin
                                if (!dm[c[i].p] && c[i].a == a) v = c[i].d;
                            end
                        end
                    end
                    r.e = e + RD - 1;
                    r.d = v;
                    rq[p].push_back(r);
                end
            end
            for (int i = 0; i < c.size(); i++) begin
                if (!dm[c[i].p]) ref_mem[c[i].a] = c[i].d;
            end
            if (dm != '0) begin
                dr.e    = e;
                dr.mask = dm;
                dq.push_back(dr);
            end
        endtask

        task automatic mon(input int n);
            logic [NP-1:0] xv;
            logic [NP-1:0] xd;
            xv = '0;
            xd = '0;
            for (int p = 0; p < NP; p++) begin
                if (rq[p].size() > 0 && rq[p][0].e == n) begin
                    xv[p]   = 1'b1;
                    last[p] = rq[p][0].d;
                    void'(rq[p].pop_front());
                end
                check($sformatf("i%0d rvalid%0d", g, p), DW'(rvalid[p]), DW'(xv[p]));
                check($sformatf("i%0d dout%0d", g, p), dout[p*DW +: DW], last[p]);
            end
            if (dq.size() > 0 && dq[0].e == n) begin
                xd = dq[0].mask;
                void'(dq.pop_front());
            end
            check($sformatf("i%0d wr_drop", g), DW'(drop), DW'(xd));
        endtask

        initial begin
            forever begin
                @(posedge clk);
                #1;
                mon(cyc - 1);
            end
        end

        task automatic tick();
            model_edge(cyc);
            @(negedge clk);
            en = '0;
            we = '0;
        endtask

        task automatic idle(input int n);
            repeat (n) tick();
        endtask

        task automatic req(input int p, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
            en[p]            = 1'b1;
            we[p]            = w;
            addr[p*AW +: AW] = a;
            din[p*DW +: DW]  = d;
        endtask

        task automatic do_reset(input int hold);
            rst_n = 1'b0;
            pend.delete();
            dq.delete();
            for (int p = 0; p < NP; p++) begin
                rq[p].delete();
                last[p] = '0;
            end
            #1;
            check($sformatf("i%0d rst rvalid", g), DW'(rvalid), '0);
            check($sformatf("i%0d rst wr_drop", g), DW'(drop), '0);
            check($sformatf("i%0d rst dout0", g), dout[0 +: DW], '0);
            check($sformatf("i%0d rst dout1", g), dout[DW +: DW], '0);
            repeat (hold) @(negedge clk);
            rst_n = 1'b1;
        endtask

        function automatic logic [AW-1:0] rand_addr();
            case ($urandom_range(3))
                0, 1:    return AW'($urandom_range(7));
                2:       return AW'(8'hC4 + $urandom_range(7));
                default: return AW'(8'hF0 + $urandom_range(3));
            endcase
        endfunction

        initial begin
            for (int p = 0; p < NP; p++) last[p] = '0;
            #1;
            do_reset(3);
            for (int a = 0; a < DEPTH; a++) begin
                req(0, 1'b1, AW'(a), $urandom);
                tick();
            end
            idle(WR + 2);
            // write lands WR-1 edges later; reads straddle the commit
            req(0, 1'b1, 8'h10, 32'hDEADBEEF);
            tick();
            tick();
            req(1, 1'b0, 8'h10, '0);
            tick();
            req(1, 1'b0, 8'h10, '0);
            tick();
            idle(RD + 2);
            for (int i = 0; i < WR; i++) begin
                if (i == 0) req(0, 1'b1, 8'h20, 32'h1);
                if (i == WR - 1) req(1, 1'b0, 8'h20, '0);
                tick();
            end
            idle(RD + 2);
            req(0, 1'b1, 8'h30, 32'hAAAA);
            req(1, 1'b1, 8'h30, 32'h5555);
            tick();
            idle(WR + 1);
            req(0, 1'b0, 8'h30, '0);
            req(1, 1'b0, 8'h30, '0);
            tick();
            idle(RD + 2);
            req(0, 1'b1, 8'hF0, 32'h77);
            tick();
            idle(WR);
            req(0, 1'b0, 8'hF0, '0);
            req(1, 1'b0, 8'hF0, '0);
            tick();
            req(0, 1'b1, 8'hC7, 32'h1234);
            tick();
            idle(WR);
            req(1, 1'b0, 8'hC7, '0);
            tick();
            idle(RD + 2);
            req(0, 1'b1, 8'h40, 32'h4040);
            tick();
            req(0, 1'b1, 8'h41, 32'h4141);
            tick();
            req(1, 1'b1, 8'h42, 32'h4242);
            tick();
            do_reset(1);
            req(0, 1'b0, 8'h40, '0);
            req(1, 1'b0, 8'h41, '0);
            tick();
            req(0, 1'b0, 8'h42, '0);
            tick();
            idle(RD + 2);
            repeat (RAND_CYCLES) begin
                for (int p = 0; p < NP; p++) begin
                    if ($urandom_range(3) != 0) begin
                        req(p, 1'($urandom_range(1)), rand_addr(), $urandom);
                    end
                end
                tick();
            end
            idle(WR + RD + 4);
            for (int p = 0; p < NP; p++) begin
                check($sformatf("i%0d leftover rd%0d", g, p), DW'(rq[p].size()), '0);
            end
            check($sformatf("i%0d leftover drop", g), DW'(dq.size()), '0);
            done = 1'b1;
        end
    end

    initial begin
        fork
            wait (g_i[0].done && g_i[1].done && g_i[2].done);
            #(2_000_000);
        join_any
        disable fork;
        check("completion", DW'(g_i[0].done && g_i[1].done && g_i[2].done), DW'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
